// File: rtl/fmul_arbiter.sv
// Round-robin arbiter sharing one multi-cycle fmul unit between NREQ requesters.
// Optional per-requester sticky flag accumulation under `FMUL_ARB_STICKY_EN`.
//
// state | meaning
// IDLE  | searching for a requester from rr_ptr, accept one operand pair
// ISSUE | mul_req pulse, operands already registered
// WAIT  | counting fmul latency, capture result on last count
// DONE  | response held until accepted
module fmul_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int LAT  = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_x,
  input  logic [NREQ*32-1:0]   req_y,
  output logic                 mul_req,
  output logic [31:0]          mul_x,
  output logic [31:0]          mul_y,
  input  logic [31:0]          mul_rslt,
  input  logic [4:0]           mul_flag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_rslt,
  output logic [4:0]           rsp_flag
`ifdef FMUL_ARB_STICKY_EN
  ,
  input  logic [NREQ-1:0]      sticky_clr,
  output logic [NREQ*5-1:0]    sticky_flag
`endif
);

  localparam int CW = $clog2(LAT + 1);
  localparam logic [IDW:0]  NREQ_W   = (IDW+1)'(NREQ);
  localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     mul_x_q, mul_x_d, mul_y_q, mul_y_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [31:0]     rsp_rslt_q, rsp_rslt_d;
  logic [4:0]      rsp_flag_q, rsp_flag_d;

  logic            grant_found;
  logic [IDW-1:0]  grant_id;
  logic [IDW:0]    idx_w;
  logic [31:0]     sel_x, sel_y;

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx_w       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_w = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (idx_w >= NREQ_W) idx_w = idx_w - NREQ_W;
      if (!grant_found && req_valid[idx_w[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = idx_w[IDW-1:0];
      end
    end
  end

  // req_ready is masked by reset because the state register is forced to IDLE there.
  always_comb begin
    sel_x     = '0;
    sel_y     = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_x = req_x[i*32 +: 32];
        sel_y = req_y[i*32 +: 32];
      end
      if (reset && (state_q == IDLE) && grant_found)
        req_ready[i] = (grant_id == IDW'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    mul_x_d    = mul_x_q;
    mul_y_d    = mul_y_q;
    rsp_id_d   = rsp_id_q;
    rsp_rslt_d = rsp_rslt_q;
    rsp_flag_d = rsp_flag_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          mul_x_d  = sel_x;
          mul_y_d  = sel_y;
          rsp_id_d = grant_id;
          rr_ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          rsp_rslt_d = mul_rslt;
          rsp_flag_d = mul_flag;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      mul_x_q    <= '0;
      mul_y_q    <= '0;
      rsp_id_q   <= '0;
      rsp_rslt_q <= '0;
      rsp_flag_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      mul_x_q    <= mul_x_d;
      mul_y_q    <= mul_y_d;
      rsp_id_q   <= rsp_id_d;
      rsp_rslt_q <= rsp_rslt_d;
      rsp_flag_q <= rsp_flag_d;
    end
  end

  assign mul_req   = (state_q == ISSUE);
  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign rsp_valid = (state_q == DONE);
  assign rsp_id    = rsp_id_q;
  assign rsp_rslt  = rsp_rslt_q;
  assign rsp_flag  = rsp_flag_q;

`ifdef FMUL_ARB_STICKY_EN
  logic [NREQ*5-1:0] sticky_q, sticky_d;

  // Clear first so a same-cycle clear and accumulate leaves just the new flags.
  always_comb begin
    sticky_d = sticky_q;
    for (int i = 0; i < NREQ; i++) begin
      if (sticky_clr[i]) sticky_d[i*5 +: 5] = '0;
      if ((state_q == DONE) && rsp_ready && (rsp_id_q == IDW'(i)))
        sticky_d[i*5 +: 5] = sticky_d[i*5 +: 5] | rsp_flag_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sticky_q <= '0;
    else        sticky_q <= sticky_d;
  end

  assign sticky_flag = sticky_q;
`endif

endmodule
